mux_scan_ctrl: RTL
==================

# mux_scan_ctrl

Sequencer that sits directly upstream of the 4-channel, 4-bit mux stage: drives its two select lines, scans the enabled channels in ascending index order, waits a programmable settle time, and captures the mux output. Each captured sample goes to a downstream consumer over a valid/ready handshake, tagged with its channel index. Supports one-shot (single frame) and continuous scanning.

## Interface
- DWELL, default 1: settle cycles between a select change and the sample capture; legal range 1..15.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a scan; honoured only in IDLE.
- cont  in  1  continuous mode; latched together with start.
- stop  in  1  request to end continuous scanning; sticky until serviced.
- chan_en  in  4  channel enable mask; bit i enables channel i.
- mux_y  in  4  data returned by the mux stage.
- out_ready  in  1  consumer ready.
- sel_s1  out  1  mux select, pair-internal: channel index bit 0.
- sel_s0  out  1  mux select, pair choice: channel index bit 1.
- out_valid  out  1  sample valid.
- out_data  out  4  captured sample.
- out_chan  out  2  index of the captured channel.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse at the end of each frame.

## Operation
- Channel mapping: channel 0/1/2/3 = {sel_s0,sel_s1} = 00/01/10/11, i.e. inputs A/B/C/D of the mux.
- States: IDLE, SETTLE, OUTPUT.
- IDLE: selects 00, busy 0, out_valid 0.
  - If start=1 and chan_en!=0: latch mask and cont, clear the stop flag, drive selects for the lowest enabled channel, load the dwell counter, go to SETTLE.
  - If start=1 and chan_en==0: ignored; stay in IDLE.
- SETTLE: decrement the dwell counter. When it expires, capture out_data<=mux_y and out_chan<=idx, assert out_valid, go to OUTPUT.
- OUTPUT: out_valid, out_data and out_chan stay stable until out_valid&&out_ready. On the handshake:
  - If idx is the highest enabled channel in the latched mask, the frame ends. Pulse frame_done.
    - If cont=1 and the stop flag is clear: re-latch chan_en. If the new mask is nonzero, continue at its lowest enabled channel in SETTLE. Otherwise go to IDLE.
    - If not continuing: go to IDLE.
  - Otherwise select the next higher enabled channel and go to SETTLE.
- chan_en changes mid-frame have no effect. The mask is sampled only at start and at frame boundaries.
- stop=1 in any busy state sets the stop flag. The current frame completes normally, then the block goes to IDLE.
- start is ignored while busy.
- Reset mid-operation aborts immediately. No handshake completion and no frame_done are produced.

## Timing
- Reset values: sel_s1=0, sel_s0=0, out_valid=0, out_data=0, out_chan=0, busy=0, frame_done=0, state IDLE, stop flag 0.
- All outputs are registered.
- start sampled at edge k: selects and busy update after edge k.
- First out_valid rises after edge k+DWELL.
- Selects always change exactly DWELL edges before the corresponding capture edge.
- Per-sample cost with out_ready held high: DWELL+1 cycles.
- frame_done is high for exactly the cycle after the final handshake of a frame.
- out_valid drops in the cycle after a handshake. There are no back-to-back valid cycles.

## Structure
- Package mux_scan_pkg holds:
  - the state enum (IDLE, SETTLE, OUTPUT);
  - the 2-bit channel index type;
  - the DWELL counter width constant (4);
  - a function mapping a channel index to {sel_s0,sel_s1}.
- Sub-module mux_scan_next_chan: combinational priority finder. Takes mask and current idx; returns the next higher enabled index, the lowest enabled index, and a last-in-frame flag.

## Test plan
- One-shot, all channels: DWELL=1, chan_en=1111, cont=0, out_ready=1, mux stage fed A=1,B=2,C=3,D=4 → samples (0,1),(1,2),(2,3),(3,4), each 2 cycles apart. Then frame_done pulses once, then IDLE with selects 00.
- Sparse mask with backpressure: chan_en=1010, out_ready low for 5 cycles on the first sample → outputs held stable for those cycles. Channels 1 then 3 delivered. Selects observed: 01 then 11.
- Continuous mode and stop: cont=1, chan_en=0101; change mask to 1000 mid-frame; assert stop during the second frame:
  - frame 1 stays on channels 0 and 2;
  - frame 2 uses channel 3 only;
  - return to IDLE after frame 2's frame_done.
- Ignored starts: start with chan_en=0000 → busy stays 0. start pulsed while busy → no restart.
- DWELL=3 latency: out_valid rises 3 edges after the start edge. mux_y changed during settle → value captured on the capture edge only.
- Reset mid-operation: assert rst_n=0 in OUTPUT → all outputs return to reset values asynchronously. No frame_done pulse.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan sequencer.
package mux_scan_pkg;

  localparam int DWELL_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    OUTPUT
  } state_e;

  typedef logic [1:0] chan_idx_t;

  // Returns {sel_s0, sel_s1}: s0 picks the pair, s1 picks within the pair.
  function automatic logic [1:0] sel_of(chan_idx_t idx);
    return {idx[1], idx[0]};
  endfunction

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Sample stream from the scan sequencer to its consumer (valid/ready).
interface mux_scan_ctrl_if;
  import mux_scan_pkg::*;

  logic       out_valid;
  logic [3:0] out_data;
  chan_idx_t  out_chan;
  logic       out_ready;

  modport master (output out_valid, out_data, out_chan, input out_ready);
  modport slave  (input out_valid, out_data, out_chan, output out_ready);
endinterface

// File: rtl/mux_scan_next_chan.sv
// Priority finder over a 4-bit channel mask: next higher enabled index,
// lowest enabled index, and whether the current index is the last one.
module mux_scan_next_chan
  import mux_scan_pkg::*;
(
  input  logic [3:0] mask_i,
  input  chan_idx_t  idx_i,
  output chan_idx_t  next_idx_o,
  output chan_idx_t  low_idx_o,
  output logic       last_o
);

  always_comb begin
    // NOTE: every output gets a default before the loops so no path leaves
    // one unassigned; otherwise synthesis infers a latch.
    next_idx_o = idx_i;
    low_idx_o  = '0;
    last_o     = 1'b1;
    // Descending scan: the final hit is the lowest qualifying bit.
    for (int i = 3; i >= 0; i--) begin
      if (mask_i[i]) low_idx_o = chan_idx_t'(i);
    end
    for (int i = 3; i >= 0; i--) begin
      if (mask_i[i] && (i > int'(idx_i))) begin
        next_idx_o = chan_idx_t'(i);
        last_o     = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans enabled mux channels in ascending order, waits DWELL settle cycles,
// captures the mux output and hands each sample downstream.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  cont,
  input  logic                  stop,
  input  logic [3:0]            chan_en,
  input  logic [3:0]            mux_y,
  output logic                  sel_s1,
  output logic                  sel_s0,
  output logic                  busy,
  output logic                  frame_done,
  mux_scan_ctrl_if.master       out_if
);

  localparam logic [DWELL_W-1:0] DWELL_LD = DWELL_W'(DWELL);

  state_e               state_q, state_d;
  logic [3:0]           mask_q, mask_d;
  logic                 cont_q, cont_d;
  logic                 stop_q, stop_d;
  chan_idx_t            idx_q, idx_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic                 valid_q, valid_d;
  logic [3:0]           data_q, data_d;
  chan_idx_t            chan_q, chan_d;
  logic [1:0]           sel_q, sel_d;
  logic                 busy_q, busy_d;
  logic                 fd_q, fd_d;

  chan_idx_t step_next, step_low_unused;
  logic      step_last;
  chan_idx_t new_low, new_next_unused;
  logic      new_last_unused;
  logic      chan_en_nz;

  // Walk within the latched mask, and find the entry point of a fresh mask.
  mux_scan_next_chan u_step (
    .mask_i     (mask_q),
    .idx_i      (idx_q),
    .next_idx_o (step_next),
    .low_idx_o  (step_low_unused),
    .last_o     (step_last)
  );

  mux_scan_next_chan u_new (
    .mask_i     (chan_en),
    .idx_i      ('0),
    .next_idx_o (new_next_unused),
    .low_idx_o  (new_low),
    .last_o     (new_last_unused)
  );

  assign chan_en_nz = |chan_en;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cont_d  = cont_q;
    stop_d  = stop_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    data_d  = data_q;
    chan_d  = chan_q;
    fd_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        idx_d   = '0;
        if (start && chan_en_nz) begin
          mask_d  = chan_en;
          cont_d  = cont;
          stop_d  = 1'b0;
          idx_d   = new_low;
          cnt_d   = DWELL_LD;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (stop) stop_d = 1'b1;
        if (cnt_q <= 1) begin
          valid_d = 1'b1;
          data_d  = mux_y;
          chan_d  = idx_q;
          state_d = OUTPUT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      OUTPUT: begin
        if (stop) stop_d = 1'b1;
        if (out_if.out_ready) begin
          valid_d = 1'b0;
          cnt_d   = DWELL_LD;
          if (step_last) begin
            fd_d = 1'b1;
            // A stop arriving on the final handshake still ends the scan.
            if (cont_q && !stop_d && chan_en_nz) begin
              mask_d  = chan_en;
              idx_d   = new_low;
              state_d = SETTLE;
            end else begin
              idx_d   = '0;
              state_d = IDLE;
            end
          end else begin
            idx_d   = step_next;
            state_d = SETTLE;
          end
        end
      end
      default: begin
        idx_d   = '0;
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase

    sel_d  = sel_of(idx_d);
    busy_d = (state_d != IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      cont_q  <= 1'b0;
      stop_q  <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      chan_q  <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cont_q  <= cont_d;
      stop_q  <= stop_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      fd_q    <= fd_d;
    end
  end

  assign sel_s0           = sel_q[1];
  assign sel_s1           = sel_q[0];
  assign busy             = busy_q;
  assign frame_done       = fd_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = data_q;
  assign out_if.out_chan  = chan_q;

endmodule
